// File: rtl/mod_pkg.sv
// Shared definitions for the modulo/divide unit: FSM state encoding and default widths.
package mod_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 32;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SUB,
        WAIT_RES,
        DONE
    } mod_state_t;

endpackage

// File: rtl/mod_ctrl.sv
// Control FSM for the iterative modulo datapath: accepts an operand pair, sequences
// load/subtract on mod_dp, counts subtract cycles and reports quotient, remainder and errors.
module mod_ctrl
    import mod_pkg::*;
#(
    parameter int WIDTH    = WIDTH_DEF,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int MAX_ITER = 65535
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] A_in,
    input  logic [WIDTH-1:0] B_in,
    output logic             ready,
    output logic             done,
    output logic [CNT_W-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             err_div0,
    output logic             err_timeout,
    output logic [WIDTH-1:0] dp_A,
    output logic [WIDTH-1:0] dp_B,
    output logic             dp_load,
    output logic             dp_subtract,
    input  logic             dp_subtract_ack,
    input  logic [WIDTH-1:0] dp_Result
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_ITER);

    mod_state_t       state_q, state_d;
    logic [WIDTH-1:0] op_a_q, op_a_d;
    logic [WIDTH-1:0] op_b_q, op_b_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             div0_q, div0_d;
    logic             tout_q, tout_d;
    logic             ready_q, ready_d;
    logic             done_q, done_d;
    logic             load_q, load_d;
    logic             sub_q, sub_d;

    // Every control output is computed for the next state so it is registered alongside it.
    always_comb begin
        state_d = state_q;
        op_a_d  = op_a_q;
        op_b_d  = op_b_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        div0_d  = div0_q;
        tout_d  = tout_q;
        done_d  = 1'b0;
        load_d  = 1'b0;
        sub_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    op_a_d = A_in;
                    op_b_d = B_in;
                    cnt_d  = '0;
                    tout_d = 1'b0;
                    quot_d = '0;
                    if (B_in == '0) begin
                        state_d = DONE;
                        div0_d  = 1'b1;
                        rem_d   = A_in;
                    end else begin
                        state_d = LOAD;
                        div0_d  = 1'b0;
                        rem_d   = '0;
                        load_d  = 1'b1;
                    end
                end
            end
            LOAD: begin
                state_d = SUB;
                sub_d   = 1'b1;
            end
            SUB: begin
                if (dp_subtract_ack) begin
                    state_d = WAIT_RES;
                end else if (cnt_q == MAX_CNT) begin
                    state_d = DONE;
                    tout_d  = 1'b1;
                    quot_d  = '1;
                    rem_d   = '0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    sub_d = 1'b1;
                end
            end
            WAIT_RES: begin
                rem_d   = dp_Result;
                quot_d  = cnt_q - 1'b1;
                state_d = DONE;
                done_d  = 1'b1;
            end
            DONE: begin
                // A divide-by-zero arrives here straight from the accept edge with done
                // still low, so it raises its pulse one edge later before leaving.
                if (done_q) begin
                    state_d = IDLE;
                end else begin
                    done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_a_q  <= '0;
            op_b_q  <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            div0_q  <= 1'b0;
            tout_q  <= 1'b0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            load_q  <= 1'b0;
            sub_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_a_q  <= op_a_d;
            op_b_q  <= op_b_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            div0_q  <= div0_d;
            tout_q  <= tout_d;
            ready_q <= ready_d;
            done_q  <= done_d;
            load_q  <= load_d;
            sub_q   <= sub_d;
        end
    end

    assign ready       = ready_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign err_div0    = div0_q;
    assign err_timeout = tout_q;
    assign dp_A        = op_a_q;
    assign dp_B        = op_b_q;
    assign dp_load     = load_q;
    assign dp_subtract = sub_q;

endmodule

// File: doc/mod_ctrl.md
# mod_ctrl

Control FSM for the iterative modulo datapath `mod_dp`. It drives `mod_dp` from the opposite side of its `load`/`subtract`/`subtract_ack` interface. It accepts an A/B operand pair from a host through a start/ready handshake, sequences the datapath, and counts subtraction cycles to report the quotient. It returns the quotient, the remainder and error flags with a one-cycle `done` pulse. `mod_ctrl` and `mod_dp` sit side by side inside the ALU's modulo/divide unit.

## Interface
Parameters:
- `WIDTH`, 32: operand and result width.
- `CNT_W`, 32: width of the iteration counter and of the quotient.
- `MAX_ITER`, 65535: maximum number of subtract cycles before abort. Must be less than 2^CNT_W.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  host request; sampled only while `ready`=1.
- `A_in`  in  WIDTH  dividend; captured on an accepted `start`.
- `B_in`  in  WIDTH  divisor; captured on an accepted `start`.
- `ready`  out  1  high only in IDLE.
- `done`  out  1  one-cycle completion pulse.
- `quotient`  out  CNT_W  number of successful subtractions.
- `remainder`  out  WIDTH  final residue.
- `err_div0`  out  1  the last operation had B=0.
- `err_timeout`  out  1  the last operation hit `MAX_ITER`.
- `dp_A`  out  WIDTH  to `mod_dp` A; registered operand.
- `dp_B`  out  WIDTH  to `mod_dp` B; registered operand, held stable for the whole operation.
- `dp_load`  out  1  to `mod_dp` load.
- `dp_subtract`  out  1  to `mod_dp` subtract.
- `dp_subtract_ack`  in  1  from `mod_dp`.
- `dp_Result`  in  WIDTH  from `mod_dp` Result.

## Operation
- States are IDLE, LOAD, SUB, WAIT_RES and DONE.
- **IDLE**:
  - `ready`=1.
  - On `start`=1, capture A and B into `opA`/`opB`, clear `cnt`, clear both error flags.
  - Go to DONE with `err_div0`=1 if B=0. Otherwise go to LOAD.
- **LOAD**:
  - `dp_load`=1 for exactly one cycle.
  - Go to SUB.
- **SUB**:
  - `dp_subtract`=1.
  - On each edge with `dp_subtract_ack`=0, `cnt`++.
  - If `dp_subtract_ack`=1, go to WAIT_RES.
  - Else if `cnt`=MAX_ITER, go to DONE with `err_timeout`=1.
- **WAIT_RES**:
  - One cycle, with `dp_subtract`=0.
  - `dp_Result` is valid in this cycle.
  - Capture `remainder`=`dp_Result` and `quotient`=`cnt`−1, then go to DONE.
- **DONE**:
  - `done`=1 for one cycle, then go to IDLE.
- **Output values on error**:
  - Division by zero: `quotient`=0 and `remainder`=A.
  - Timeout: `quotient`=all-ones and `remainder`=0.
- **Output hold**: `quotient`, `remainder` and both error flags hold their values until the next accepted `start`.
- **Ignored inputs**: `start` in any state other than IDLE is ignored. `A_in` and `B_in` are don't-care outside the accept edge.
- **Datapath contract**:
  - `dp_subtract_ack` is registered and was cleared by the LOAD edge, so a stale ack is never seen in SUB.
  - `dp_Result` updates one edge after the ack rises.
- **Timeout recovery**: after a timeout the datapath may still be processing. The next LOAD reinitialises it, and no flush is required.
- **Arithmetic**: unsigned throughout. `cnt` never wraps because the MAX_ITER check precedes the increment.

## Timing
- **Reset values**: IDLE, `ready`=1, every other output 0, `opA`/`opB`/`cnt` = 0.
- **Latency**: count the edge that samples `start` as edge 1. Then `done` rises after edge q+5 (q = quotient) and stays high for one cycle. `ready` returns high on the following edge.
- **Divide by zero**: `done` rises after edge 2.
- **Timeout**: `done` rises after edge MAX_ITER+3.
- **Reset mid-operation**: asynchronous return to reset values. No `done` is generated, and results are cleared. `mod_dp` shares `reset`.
- **Back-to-back operations**: minimum start-to-start spacing is q+6 cycles.

## Structure
- Shared package `mod_pkg`:
  - `mod_state_t` enum (IDLE, LOAD, SUB, WAIT_RES, DONE).
  - `WIDTH_DEF`=32 and `CNT_W_DEF`=32.
  - Later blocks in the unit reuse this package.
- `mod_ctrl` has no sub-module: one FSM plus operand, counter and result registers.
- Integration: a wrapper `mod_unit` instantiates `mod_ctrl` and `mod_dp` and connects the `dp_*` ports. That wrapper is the bench's DUT for end-to-end tests.

## Test plan
- **Normal divide**: A=7, B=3, start → `done` after edge 7; `quotient`=2, `remainder`=1, both error flags 0.
- **A less than B**: A=2, B=5 → `done` after edge 5; `quotient`=0, `remainder`=2.
- **Divide by zero**: A=9, B=0 → `done` after edge 2; `err_div0`=1, `quotient`=0, `remainder`=9, `dp_load` never asserted.
- **Timeout**: MAX_ITER=4, A=100, B=1 → `err_timeout`=1, `quotient`=all-ones, `remainder`=0. A following A=10, B=4 → `quotient`=2, `remainder`=2.
- **Reset mid-operation**: assert `reset` mid-SUB during A=1000, B=7 → all outputs 0 immediately, `ready`=1. A following A=1000, B=7 → `quotient`=142, `remainder`=6.
- **Start while busy**: `start` with A=50, B=5 held high through the whole operation is accepted once → one `done`, `quotient`=10, `remainder`=0. Operands changed mid-operation have no effect.
